// File: rtl/branch_predictor_gshare.sv
// Gshare branch direction predictor.
// A pattern history table of saturating counters is indexed by the branch
// address XORed with the global history register. After reset the table is
// swept once (one entry per cycle) to "weakly not-taken" before requests are
// accepted. Predictions return one cycle after the request. Updates train one
// counter, shift the outcome into the history, and count mispredicts.
module branch_predictor_gshare #(
    parameter int IDX_W  = 10,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              pred_valid,
    input  logic [IDX_W-1:0]  pred_addr,
    output logic              resp_valid,
    output logic              resp_taken,
    output logic [IDX_W-1:0]  resp_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [HIST_W-1:0] ghr,
    output logic [15:0]       miss_cnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [15:0]        miss_q, miss_d;
    logic               resp_valid_q;
    logic               resp_taken_q;
    logic [IDX_W-1:0]   resp_idx_q;
    logic [CTR_W-1:0]   pht_q [DEPTH];

    logic               run;
    logic               pred_fire;
    logic               upd_fire;
    logic [IDX_W-1:0]   pred_idx;
    logic [CTR_W-1:0]   upd_ctr;

    // Saturating up/down step of a single counter.
    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] cur,
                                                  input logic             taken);
        logic [CTR_W-1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_MAX) nxt = cur + 1'b1;
        end else begin
            if (cur != CTR_ZERO) nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

    assign run       = (state_q == S_RUN);
    assign pred_fire = run & pred_valid;
    assign upd_fire  = run & upd_valid;
    assign pred_idx  = pred_addr ^ IDX_W'(ghr_q);
    assign upd_ctr   = ctr_step(pht_q[upd_idx], upd_taken);

    // Next state for the init sweep: advance the pointer, leave INIT after the last entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(DEPTH - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    // Next history and mispredict count, only moved by accepted updates.
    always_comb begin
        ghr_d  = ghr_q;
        miss_d = miss_q;
        if (upd_fire) begin
            ghr_d = (ghr_q << 1) | HIST_W'(upd_taken);
            if ((upd_pred != upd_taken) && (miss_q != 16'hFFFF)) begin
                miss_d = miss_q + 16'd1;
            end
        end
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            ptr_q        <= '0;
            ghr_q        <= '0;
            miss_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ghr_q        <= ghr_d;
            miss_q       <= miss_d;
            resp_valid_q <= pred_fire;
            if (pred_fire) begin
                resp_taken_q <= pht_q[pred_idx][CTR_W-1];
                resp_idx_q   <= pred_idx;
            end
        end
    end

    // Table storage: init sweep writes, otherwise training writes; reads are pre-edge values.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            pht_q[ptr_q] <= CTR_INIT;
        end else if (upd_valid) begin
            pht_q[upd_idx] <= upd_ctr;
        end
    end

    assign ready      = run;
    assign resp_valid = resp_valid_q;
    assign resp_taken = resp_taken_q;
    assign resp_idx   = resp_idx_q;
    assign ghr        = ghr_q;
    assign miss_cnt   = miss_q;

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001: The block SHALL have parameter IDX_W, default 10, which is the pattern-table index width; the table holds 2^IDX_W entries.
REQ-002: The block SHALL have parameter CTR_W, default 2, which is the saturating-counter width; legal range 2..4.
REQ-003: The block SHALL have parameter HIST_W, default 8, which is the global-history width; legal range 1..IDX_W.
REQ-004: The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005: The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006: The block SHALL have port ready, output, 1 bit: 1 when table initialisation is complete and requests are accepted.
REQ-007: The block SHALL have port pred_valid, input, 1 bit: prediction request strobe.
REQ-008: The block SHALL have port pred_addr, input, IDX_W bits: branch address bits used for indexing.
REQ-009: The block SHALL have port resp_valid, output, 1 bit: prediction response strobe.
REQ-010: The block SHALL have port resp_taken, output, 1 bit: predicted direction, 1 = taken.
REQ-011: The block SHALL have port resp_idx, output, IDX_W bits: table index used, returned later on update.
REQ-012: The block SHALL have port upd_valid, input, 1 bit: resolved-branch update strobe.
REQ-013: The block SHALL have port upd_idx, input, IDX_W bits: index to train.
REQ-014: The block SHALL have port upd_taken, input, 1 bit: actual outcome.
REQ-015: The block SHALL have port upd_pred, input, 1 bit: direction that was predicted for this branch.
REQ-016: The block SHALL have port ghr, output, HIST_W bits: current global history register.
REQ-017: The block SHALL have port miss_cnt, output, 16 bits: saturating mispredict count.

Function
REQ-018: The block SHALL run a two-state FSM: INIT, then RUN; INIT is entered on reset, and INIT goes to RUN after the last table entry is written; RUN has no exit except reset.
REQ-019: In INIT the block SHALL write one entry per cycle, ascending from index 0, with value 2^(CTR_W-1)-1 (weakly not-taken); INIT lasts exactly 2^IDX_W cycles after rst_n deasserts; ready = 1 only in RUN.
REQ-020: In INIT the block SHALL ignore pred_valid and upd_valid: no response, and no change to the GHR or miss_cnt.
REQ-021: The block SHALL form the index as pred_addr XOR {zero-extend(ghr)}, with ghr in the low HIST_W bits.
REQ-022: The block SHALL have a prediction latency of 1 cycle: pred_valid sampled high at edge t gives resp_valid = 1 for exactly the cycle after t, with resp_taken = MSB of the indexed counter and resp_idx = the computed index.
REQ-023: Back-to-back predictions each cycle SHALL be supported, giving one response per request, in order.
REQ-024: On upd_valid, the counter at upd_idx SHALL increment if upd_taken = 1 and decrement otherwise, saturating at 2^CTR_W-1 and at 0 with no wrap.
REQ-025: On upd_valid, ghr SHALL become {ghr[HIST_W-2:0], upd_taken}; for HIST_W = 1, ghr becomes upd_taken.
REQ-026: On upd_valid with upd_pred != upd_taken, miss_cnt SHALL increment, saturating at 16'hFFFF.
REQ-027: For a simultaneous prediction and update in one cycle, the prediction SHALL use the ghr and counter values from before that cycle's update (read-before-write), including when the index is the same.
REQ-028: Two updates SHALL never coincide, because there is a single update port; an update whose upd_idx equals the entry just trained SHALL accumulate.
REQ-029: Counter updates and ghr updates SHALL take effect at the edge that samples upd_valid.

Reset
REQ-030: While rst_n = 0, the block SHALL asynchronously force ready = 0, resp_valid = 0, resp_taken = 0, resp_idx = 0, ghr = 0, miss_cnt = 0, the init pointer = 0, and FSM = INIT.
REQ-031: Reset asserted mid-INIT or mid-RUN SHALL abort all activity; after deassertion a full 2^IDX_W-cycle INIT reruns, and no response is issued for requests in flight.
REQ-032: Table contents SHALL NOT require an asynchronous clear; INIT overwrites every entry.

Verification (defaults IDX_W=10, CTR_W=2, HIST_W=8)
REQ-033: Release rst_n, then count cycles -> ready rises after exactly 1024 cycles; then predict addr 0x3A7 -> next cycle resp_valid = 1, resp_taken = 0, resp_idx = 0x3A7.
REQ-034: In RUN with ghr = 0, send upd idx 5 taken (upd_pred = 0) twice, then predict addr 5 -> first update gives ghr = 0x01 and miss_cnt = 1; the bench predicts addr 5 ^ 0x03 -> resp_idx = 5 and resp_taken = 1 (counter = 3); a third taken update leaves the counter at 3.
REQ-035: Send updates with outcomes T,N,T,T -> ghr = 0x0B; a concurrent prediction in the 4th update cycle uses ghr = 0x05.
REQ-036: Predict and update idx 9 (not-taken, counter 1 -> 0) in the same cycle -> resp_taken = MSB of old value 1, i.e. 0, and a later read shows counter 0; with the counter at 2, decrementing to 1 -> resp_taken = 1 in the same cycle.
REQ-037: Preload miss_cnt to 0xFFFE via 65534 mispredicts, then send 3 more -> miss_cnt = 0xFFFF and holds.
REQ-038: Assert rst_n low at INIT cycle 500, then release -> ready stays 0 for a full 1024 cycles; outputs are 0 during reset.
